// File: rtl/axi_slave_wr_mux.sv
// N-master to 1-slave AXI write-path multiplexer (one slave leg of the crossbar).
// AW is arbitrated round-robin; W beats follow AW grant order through an order
// FIFO; B responses are routed back by the master index embedded in the slave ID.
module axi_slave_wr_mux #(
  parameter int NUM_M    = 3,
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MID_W    = 4,
  parameter int SID_W    = 8,
  parameter int WQ_DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_M-1:0]          m_awvalid,
  output logic [NUM_M-1:0]          m_awready,
  input  logic [NUM_M*MID_W-1:0]    m_awid,
  input  logic [NUM_M*ADDR_W-1:0]   m_awaddr,
  input  logic [NUM_M*8-1:0]        m_awlen,
  input  logic [NUM_M*3-1:0]        m_awsize,
  input  logic [NUM_M*2-1:0]        m_awburst,
  input  logic [NUM_M-1:0]          m_wvalid,
  output logic [NUM_M-1:0]          m_wready,
  input  logic [NUM_M-1:0]          m_wlast,
  input  logic [NUM_M*DATA_W-1:0]   m_wdata,
  input  logic [NUM_M*DATA_W/8-1:0] m_wstrb,
  output logic [NUM_M-1:0]          m_bvalid,
  input  logic [NUM_M-1:0]          m_bready,
  output logic [NUM_M*MID_W-1:0]    m_bid,
  output logic [NUM_M*2-1:0]        m_bresp,
  output logic                      s_awvalid,
  input  logic                      s_awready,
  output logic [SID_W-1:0]          s_awid,
  output logic [ADDR_W-1:0]         s_awaddr,
  output logic [7:0]                s_awlen,
  output logic [2:0]                s_awsize,
  output logic [1:0]                s_awburst,
  output logic                      s_wvalid,
  input  logic                      s_wready,
  output logic                      s_wlast,
  output logic [DATA_W-1:0]         s_wdata,
  output logic [DATA_W/8-1:0]       s_wstrb,
  input  logic                      s_bvalid,
  output logic                      s_bready,
  input  logic [SID_W-1:0]          s_bid,
  input  logic [1:0]                s_bresp,
  output logic                      wlast_err,
  output logic                      bid_err
);

  localparam int IW = $clog2(NUM_M);
  localparam int SW = DATA_W / 8;
  localparam int PW = $clog2(WQ_DEPTH);

  // Per-master views of the packed buses
  logic [MID_W-1:0]  awid_a  [NUM_M];
  logic [ADDR_W-1:0] awaddr_a[NUM_M];
  logic [7:0]        awlen_a [NUM_M];
  logic [2:0]        awsize_a[NUM_M];
  logic [1:0]        awbrst_a[NUM_M];
  logic [DATA_W-1:0] wdata_a [NUM_M];
  logic [SW-1:0]     wstrb_a [NUM_M];

  // Slice the packed master buses into arrays
  always_comb begin
    for (int i = 0; i < NUM_M; i++) begin
      awid_a[i]   = m_awid[i*MID_W +: MID_W];
      awaddr_a[i] = m_awaddr[i*ADDR_W +: ADDR_W];
      awlen_a[i]  = m_awlen[i*8 +: 8];
      awsize_a[i] = m_awsize[i*3 +: 3];
      awbrst_a[i] = m_awburst[i*2 +: 2];
      wdata_a[i]  = m_wdata[i*DATA_W +: DATA_W];
      wstrb_a[i]  = m_wstrb[i*SW +: SW];
    end
  end

  // Arbitration and order-FIFO state
  logic [IW-1:0] rr_ptr;
  logic [IW-1:0] win;
  logic          found;
  logic [IW:0]   cand;
  logic          grant;
  logic          can_grant;

  logic [IW-1:0] q_m   [WQ_DEPTH];
  logic [7:0]    q_len [WQ_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0]   count;
  logic          empty, full;
  logic [IW-1:0] head_m;
  logic [7:0]    head_len;
  logic          w_hs, pop;
  logic [7:0]    beat_cnt;
  logic [SID_W-1:0] id_ext;

  assign empty    = (count == '0);
  assign full     = (count == (PW+1)'(WQ_DEPTH));
  assign head_m   = q_m[rd_ptr];
  assign head_len = q_len[rd_ptr];

  // Round-robin search: first requester at or after rr_ptr, wrapping
  always_comb begin
    found = 1'b0;
    win   = '0;
    cand  = '0;
    for (int k = 0; k < NUM_M; k++) begin
      cand = {1'b0, rr_ptr} + (IW+1)'(k);
      if (cand >= (IW+1)'(NUM_M)) cand = cand - (IW+1)'(NUM_M);
      if (!found && m_awvalid[cand[IW-1:0]]) begin
        found = 1'b1;
        win   = cand[IW-1:0];
      end
    end
  end

  // A full FIFO still accepts a grant when its head burst retires this cycle
  assign can_grant = (!s_awvalid || s_awready) && (!full || pop);
  assign grant     = found && can_grant && !reset;

  // One-hot AW ready to the winning master
  always_comb begin
    m_awready = '0;
    if (grant) m_awready[win] = 1'b1;
  end

  // Slave ID = {zero pad, master index, master ID}
  always_comb begin
    id_ext                      = '0;
    id_ext[MID_W-1:0]           = awid_a[win];
    id_ext[MID_W+IW-1:MID_W]    = win;
  end

  // AW output register and round-robin pointer
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s_awvalid <= 1'b0;
      s_awid    <= '0;
      s_awaddr  <= '0;
      s_awlen   <= '0;
      s_awsize  <= '0;
      s_awburst <= '0;
      rr_ptr    <= '0;
    end else if (grant) begin
      s_awvalid <= 1'b1;
      s_awid    <= id_ext;
      s_awaddr  <= awaddr_a[win];
      s_awlen   <= awlen_a[win];
      s_awsize  <= awsize_a[win];
      s_awburst <= awbrst_a[win];
      rr_ptr    <= (win == IW'(NUM_M-1)) ? '0 : win + IW'(1);
    end else if (s_awready) begin
      s_awvalid <= 1'b0;
    end
  end

  // Order-FIFO storage; contents are meaningless while the slot is free
  always_ff @(posedge clk) begin
    if (grant) begin
      q_m[wr_ptr]   <= win;
      q_len[wr_ptr] <= awlen_a[win];
    end
  end

  // Order-FIFO pointers and occupancy
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (grant) wr_ptr <= wr_ptr + PW'(1);
      if (pop)   rd_ptr <= rd_ptr + PW'(1);
      case ({grant, pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // W steering to the master at the FIFO head; W before its AW waits
  always_comb begin
    s_wvalid = 1'b0;
    s_wdata  = wdata_a[head_m];
    s_wstrb  = wstrb_a[head_m];
    s_wlast  = m_wlast[head_m];
    m_wready = '0;
    if (!empty) begin
      s_wvalid         = m_wvalid[head_m];
      m_wready[head_m] = s_wready;
    end
  end

  assign w_hs = s_wvalid && s_wready;
  assign pop  = w_hs && s_wlast;

  // Beat counter and sticky WLAST/AWLEN disagreement flag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      beat_cnt  <= '0;
      wlast_err <= 1'b0;
    end else if (w_hs) begin
      if ((beat_cnt == head_len) != s_wlast) wlast_err <= 1'b1;
      beat_cnt <= s_wlast ? 8'd0 : beat_cnt + 8'd1;
    end
  end

  // B routing by the master index carried in the slave ID
  logic [IW-1:0] bidx;
  logic          b_in;
  assign bidx = s_bid[MID_W+IW-1:MID_W];
  assign b_in = ({1'b0, bidx} < (IW+1)'(NUM_M));

  generate
    if (SID_W > MID_W + IW) begin : g_bid_pad
      logic bid_pad_unused;
      assign bid_pad_unused = ^s_bid[SID_W-1:MID_W+IW];
    end
  endgenerate

  // Out-of-range indices are swallowed with a one-cycle error pulse
  always_comb begin
    m_bvalid = '0;
    m_bid    = '0;
    m_bresp  = '0;
    s_bready = 1'b0;
    bid_err  = 1'b0;
    if (!reset) begin
      if (b_in) begin
        s_bready = m_bready[bidx];
        for (int i = 0; i < NUM_M; i++) begin
          if (bidx == IW'(i)) begin
            m_bvalid[i]              = s_bvalid;
            m_bid[i*MID_W +: MID_W]  = s_bid[MID_W-1:0];
            m_bresp[i*2 +: 2]        = s_bresp;
          end
        end
      end else begin
        s_bready = 1'b1;
        bid_err  = s_bvalid;
      end
    end
  end

endmodule

// File: tb/tb_axi_slave_wr_mux.sv
// Self-checking bench for axi_slave_wr_mux (3 masters): directed scenarios
// followed by randomized traffic, all checked against a queue-based model.
module tb_axi_slave_wr_mux;

  localparam int NM = 3;
  localparam int QD = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  m_awvalid, m_awready;
  logic [11:0] m_awid;
  logic [95:0] m_awaddr;
  logic [23:0] m_awlen;
  logic [8:0]  m_awsize;
  logic [5:0]  m_awburst;
  logic [2:0]  m_wvalid, m_wready, m_wlast;
  logic [95:0] m_wdata;
  logic [11:0] m_wstrb;
  logic [2:0]  m_bvalid, m_bready;
  logic [11:0] m_bid;
  logic [5:0]  m_bresp;
  logic        s_awvalid, s_awready;
  logic [7:0]  s_awid;
  logic [31:0] s_awaddr;
  logic [7:0]  s_awlen;
  logic [2:0]  s_awsize;
  logic [1:0]  s_awburst;
  logic        s_wvalid, s_wready, s_wlast;
  logic [31:0] s_wdata;
  logic [3:0]  s_wstrb;
  logic        s_bvalid, s_bready;
  logic [7:0]  s_bid;
  logic [1:0]  s_bresp;
  logic        wlast_err, bid_err;

  always #5 clk = ~clk;

  axi_slave_wr_mux #(.NUM_M(NM), .ADDR_W(32), .DATA_W(32), .MID_W(4), .SID_W(8), .WQ_DEPTH(QD)) dut (
    .clk(clk), .reset(reset),
    .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awid(m_awid), .m_awaddr(m_awaddr),
    .m_awlen(m_awlen), .m_awsize(m_awsize), .m_awburst(m_awburst),
    .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wlast(m_wlast), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
    .m_bvalid(m_bvalid), .m_bready(m_bready), .m_bid(m_bid), .m_bresp(m_bresp),
    .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awid(s_awid), .s_awaddr(s_awaddr),
    .s_awlen(s_awlen), .s_awsize(s_awsize), .s_awburst(s_awburst),
    .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wlast(s_wlast), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
    .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bid(s_bid), .s_bresp(s_bresp),
    .wlast_err(wlast_err), .bid_err(bid_err)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model: outstanding bursts as a queue of {master, awlen}
  typedef struct { int m; int len; } ent_t;
  ent_t        q[$];
  int          ptr;
  bit          aw_v;
  logic [7:0]  aw_id;
  logic [31:0] aw_addr;
  logic [7:0]  aw_len;
  logic [2:0]  aw_size;
  logic [1:0]  aw_burst;
  int          beat;
  bit          werr;
  logic [2:0]  gvec;

  task automatic model_reset();
    q.delete();
    ptr = 0; aw_v = 0; aw_id = '0; aw_addr = '0; aw_len = '0; aw_size = '0; aw_burst = '0;
    beat = 0; werr = 0; gvec = '0;
  endtask

  task automatic mid();
    #4;
  endtask

  // Compare all outputs against the model, then advance the model one clock
  task automatic fin();
    int h, w, bi, j;
    bit e_swv, hs, pop, gok, e_sbr, e_berr;
    logic [2:0] e_mwr, e_awr, e_bv;
    h = 0; w = -1; e_swv = 0; e_mwr = '0; hs = 0; pop = 0;
    if (q.size() > 0) begin
      h = q[0].m;
      e_swv = m_wvalid[h];
      e_mwr = s_wready ? 3'(1 << h) : 3'b000;
    end
    hs  = e_swv && s_wready;
    pop = hs && m_wlast[h];
    chk("m_wready", m_wready, e_mwr);
    chk("s_wvalid", s_wvalid, e_swv);
    if (e_swv) begin
      chk("s_wdata", s_wdata, m_wdata[h*32 +: 32]);
      chk("s_wstrb", s_wstrb, m_wstrb[h*4 +: 4]);
      chk("s_wlast", s_wlast, m_wlast[h]);
    end
    gok = (!aw_v || s_awready) && (q.size() < QD || pop);
    for (int k = 0; k < NM; k++) begin
      j = (ptr + k) % NM;
      if (w < 0 && m_awvalid[j]) w = j;
    end
    if (!gok) w = -1;
    e_awr = (w >= 0) ? 3'(1 << w) : 3'b000;
    chk("m_awready", m_awready, e_awr);
    chk("s_awvalid", s_awvalid, aw_v);
    if (aw_v) begin
      chk("s_awid", s_awid, aw_id);
      chk("s_awaddr", s_awaddr, aw_addr);
      chk("s_awlen", s_awlen, aw_len);
      chk("s_awsize", s_awsize, aw_size);
      chk("s_awburst", s_awburst, aw_burst);
    end
    chk("wlast_err", wlast_err, werr);
    bi = int'(s_bid[5:4]);
    if (bi < NM) begin
      e_bv = s_bvalid ? 3'(1 << bi) : 3'b000; e_sbr = m_bready[bi]; e_berr = 0;
    end else begin
      e_bv = 3'b000; e_sbr = 1; e_berr = s_bvalid;
    end
    chk("m_bvalid", m_bvalid, e_bv);
    chk("s_bready", s_bready, e_sbr);
    chk("bid_err", bid_err, e_berr);
    if (bi < NM && s_bvalid) begin
      chk("m_bid", m_bid[bi*4 +: 4], s_bid[3:0]);
      chk("m_bresp", m_bresp[bi*2 +: 2], s_bresp);
    end
    if (hs) begin
      if ((beat == q[0].len) != m_wlast[h]) werr = 1;
      if (m_wlast[h]) begin
        void'(q.pop_front());
        beat = 0;
      end else beat = (beat + 1) % 256;
    end
    if (w >= 0) begin
      q.push_back('{w, int'(m_awlen[w*8 +: 8])});
      aw_v = 1;
      aw_id = 8'((w << 4) | int'(m_awid[w*4 +: 4]));
      aw_addr = m_awaddr[w*32 +: 32];
      aw_len = m_awlen[w*8 +: 8];
      aw_size = m_awsize[w*3 +: 3];
      aw_burst = m_awburst[w*2 +: 2];
      ptr = (w + 1) % NM;
    end else if (s_awready) aw_v = 0;
    gvec = e_awr;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    m_awvalid = '0; m_awid = '0; m_awaddr = '0; m_awlen = '0; m_awsize = '0; m_awburst = '0;
    m_wvalid = '0; m_wlast = '0; m_wdata = '0; m_wstrb = '0; m_bready = '0;
    s_awready = 0; s_wready = 0; s_bvalid = 0; s_bid = '0; s_bresp = '0;
  endtask

  initial begin
    bit wl;
    idle_inputs();
    model_reset();
    reset = 1;
    m_awvalid = 3'b111;
    s_bvalid = 1;
    #3;
    chk("rst_s_awvalid", s_awvalid, 0);
    chk("rst_m_awready", m_awready, 0);
    chk("rst_m_wready", m_wready, 0);
    chk("rst_m_bvalid", m_bvalid, 0);
    chk("rst_wlast_err", wlast_err, 0);
    chk("rst_bid_err", bid_err, 0);
    @(posedge clk); #1;
    reset = 0;
    idle_inputs();

    // Three simultaneous AW requests, granted in round-robin order
    m_awvalid = 3'b111; m_awid = {4'd3, 4'd2, 4'd1};
    m_awaddr = {32'h3000, 32'h2000, 32'h1000}; s_awready = 1;
    mid(); chk("t1_gnt0", m_awready, 3'b001); fin(); m_awvalid[0] = 0;
    mid(); chk("t1_gnt1", m_awready, 3'b010); chk("t1_awv0", s_awvalid, 1); chk("t1_id0", s_awid, 8'h01); fin(); m_awvalid[1] = 0;
    mid(); chk("t1_gnt2", m_awready, 3'b100); chk("t1_id1", s_awid, 8'h12); fin(); m_awvalid[2] = 0;
    mid(); chk("t1_id2", s_awid, 8'h23); chk("t1_nogrant", m_awready, 3'b000); fin();
    s_wready = 1; m_wvalid = 3'b111; m_wlast = 3'b111; m_wdata = {32'hCCCC, 32'hBBBB, 32'hAAAA};
    repeat (3) begin mid(); fin(); end
    mid(); chk("t1_drained", m_wready, 3'b000); fin();
    m_wvalid = '0; m_wlast = '0;

    // W from master 0 ahead of its AW waits behind master 1's 4-beat burst
    m_wvalid = 3'b001; m_awvalid = 3'b010; m_awlen[15:8] = 8'd3; m_awid[7:4] = 4'd7;
    mid(); chk("t2_gnt", m_awready, 3'b010); chk("t2_m0_wait", m_wready, 3'b000); fin();
    m_awvalid = '0; m_wvalid = 3'b011;
    for (int b = 0; b < 4; b++) begin
      m_wlast = (b == 3) ? 3'b010 : 3'b000;
      m_wdata[63:32] = 32'(b + 100);
      mid(); chk("t2_beat", m_wready, 3'b010); fin();
    end
    mid(); chk("t2_after_pop", m_wready, 3'b000); chk("t2_werr", wlast_err, 0); fin();
    m_wvalid = '0; m_wlast = '0; m_awlen = '0;

    // FIFO full blocks AW; the retiring burst frees a slot in the same cycle
    s_wready = 0; m_awvalid = 3'b111; s_awready = 1;
    repeat (4) begin mid(); fin(); end
    mid(); chk("t3_full_block", m_awready, 3'b000); fin();
    mid(); chk("t3_full_block2", m_awready, 3'b000); fin();
    m_wvalid = 3'b111; m_wlast = 3'b111; s_wready = 1;
    mid(); chk("t3_pop", s_wvalid & s_wlast, 1); chk("t3_grant_on_pop", m_awready != 3'b000, 1); fin();
    m_awvalid = '0;
    repeat (6) begin mid(); fin(); end
    m_wvalid = '0; m_wlast = '0; s_wready = 0;

    // B response routed to master 2 with backpressure
    s_bvalid = 1; s_bid = 8'h25; s_bresp = 2'd2; m_bready = 3'b000;
    repeat (3) begin
      mid();
      chk("t4_bvalid", m_bvalid, 3'b100); chk("t4_bid", m_bid[11:8], 4'd5);
      chk("t4_bresp", m_bresp[5:4], 2'd2); chk("t4_bready_lo", s_bready, 0);
      fin();
    end
    m_bready = 3'b100;
    mid(); chk("t4_bready_hi", s_bready, 1); fin();
    s_bvalid = 0; m_bready = '0;

    // Early WLAST sets the sticky error; out-of-range B index is swallowed
    m_awvalid = 3'b001; m_awlen[7:0] = 8'd1;
    mid(); chk("t5_gnt", m_awready, 3'b001); fin();
    m_awvalid = '0; m_wvalid = 3'b001; m_wlast = 3'b001; s_wready = 1;
    mid(); chk("t5_hs", m_wready[0], 1); fin();
    m_wvalid = '0; m_wlast = '0;
    mid(); chk("t5_werr", wlast_err, 1); fin();
    s_bvalid = 1; s_bid = 8'h35; s_bresp = 2'd0;
    mid(); chk("t5_bready", s_bready, 1); chk("t5_bid_err", bid_err, 1); chk("t5_no_bvalid", m_bvalid, 3'b000); fin();
    s_bvalid = 0;
    mid(); chk("t5_bid_err_off", bid_err, 0); chk("t5_werr_sticky", wlast_err, 1); fin();

    // Reset in the middle of a burst with two bursts queued
    m_awvalid = 3'b011; m_awlen = {8'd0, 8'd3, 8'd3}; s_awready = 1; s_wready = 0;
    repeat (2) begin mid(); fin(); end
    m_awvalid = '0; m_wvalid = 3'b011; m_wlast = '0; s_wready = 1;
    mid(); fin();
    m_awvalid = 3'b111; s_bvalid = 1; s_bid = 8'h05;
    reset = 1;
    #1;
    chk("t6_m_awready", m_awready, 3'b000); chk("t6_m_wready", m_wready, 3'b000);
    chk("t6_s_wvalid", s_wvalid, 0); chk("t6_s_awvalid", s_awvalid, 0);
    chk("t6_m_bvalid", m_bvalid, 3'b000); chk("t6_s_bready", s_bready, 0);
    chk("t6_wlast_err", wlast_err, 0); chk("t6_bid_err", bid_err, 0);
    model_reset();
    @(posedge clk); #1;
    reset = 0; s_bvalid = 0; m_wvalid = '0;
    mid(); chk("t6_prio", m_awready, 3'b001); fin();
    idle_inputs();

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < NM; i++) begin
        if (gvec[i]) m_awvalid[i] = 0;
        if (!m_awvalid[i] && $urandom_range(0, 1) == 1) begin
          m_awvalid[i] = 1;
          m_awid[i*4 +: 4] = 4'($urandom());
          m_awaddr[i*32 +: 32] = $urandom();
          m_awlen[i*8 +: 8] = 8'($urandom_range(0, 3));
          m_awsize[i*3 +: 3] = 3'($urandom());
          m_awburst[i*2 +: 2] = 2'($urandom());
        end
        if (q.size() > 0 && q[0].m == i) wl = (beat == q[0].len);
        else wl = 1'($urandom());
        if (c > 2000 && $urandom_range(0, 63) == 0) wl = !wl;
        m_wlast[i] = wl;
      end
      m_wvalid = 3'($urandom());
      m_wdata = {$urandom(), $urandom(), $urandom()};
      m_wstrb = 12'($urandom());
      s_awready = ($urandom_range(0, 3) != 0);
      s_wready = ($urandom_range(0, 3) != 0);
      s_bvalid = 1'($urandom());
      s_bid = 8'($urandom());
      s_bresp = 2'($urandom());
      m_bready = 3'($urandom());
      mid();
      fin();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/axi_slave_wr_mux.md
Name: axi_slave_wr_mux

Overview:
- Parametrised N-master to 1-slave AXI write-path multiplexer. It is the per-slave write leg of the crossbar, generalising the fixed 3x3 wiring to NUM_M masters.
- Round-robin arbitration on AW. W-beat steering follows AW grant order through an order FIFO.
- Slave-side IDs are extended with the master index; B responses are routed back by that index.
- WLAST/AWLEN consistency is checked and reported.

Parameters:
- NUM_M, 3, number of master ports (2..8).
- ADDR_W, 32, address width.
- DATA_W, 32, data width; strobe width is DATA_W/8.
- MID_W, 4, master-side ID width.
- SID_W, 8, slave-side ID width; must be >= MID_W+clog2(NUM_M).
- WQ_DEPTH, 4, depth of the W-order FIFO (power of 2).

Ports:
- clk, in, 1, clock.
- reset, in, 1, asynchronous active-high reset.
- m_awvalid/m_awready, in/out, NUM_M, per-master AW handshake.
- m_awid, in, NUM_M*MID_W, packed per master.
- m_awaddr, in, NUM_M*ADDR_W, packed per master.
- m_awlen, in, NUM_M*8, packed per master.
- m_awsize, in, NUM_M*3, packed per master.
- m_awburst, in, NUM_M*2, packed per master.
- m_wvalid/m_wready/m_wlast, in/out/in, NUM_M, per-master W handshake and last flag.
- m_wdata, in, NUM_M*DATA_W, packed per master.
- m_wstrb, in, NUM_M*DATA_W/8, packed per master.
- m_bvalid/m_bready, out/in, NUM_M, per-master B handshake.
- m_bid, out, NUM_M*MID_W, packed per master.
- m_bresp, out, NUM_M*2, packed per master.
- s_awvalid/s_awready, out/in, 1, slave AW handshake.
- s_awid, out, SID_W, slave AW ID.
- s_awaddr, out, ADDR_W, slave AW address.
- s_awlen, out, 8, slave AW burst length.
- s_awsize, out, 3, slave AW size.
- s_awburst, out, 2, slave AW burst type.
- s_wvalid/s_wready/s_wlast, out/in/out, 1, slave W handshake and last flag.
- s_wdata, out, DATA_W, slave W data.
- s_wstrb, out, DATA_W/8, slave W strobe.
- s_bvalid/s_bready, in/out, 1, slave B handshake.
- s_bid, in, SID_W, slave B ID.
- s_bresp, in, 2, slave B response.
- wlast_err, out, 1, sticky: WLAST position disagreed with AWLEN.
- bid_err, out, 1, one-cycle pulse: B response carried an out-of-range index.

Behaviour:
- Clock is clk; reset is asynchronous, active-high. On reset assertion:
  - s_awvalid=0 and the AW register is cleared.
  - Round-robin pointer is 0, so master 0 has highest priority first.
  - W-order FIFO is empty and the beat counter is 0.
  - wlast_err=0 and bid_err=0.
  - All m_*ready=0 and m_bvalid=0.
- Reset mid-burst discards the in-flight transaction; no recovery beats are emitted.
- AW arbitration:
  - A grant is possible when the AW output register is empty, or is being accepted this cycle (s_awvalid&s_awready), and the FIFO is not full.
  - Winner is the first requesting master at or after the pointer, wrapping modulo NUM_M.
  - m_awready[winner]=1 for exactly that cycle. The AW fields are captured and s_awvalid rises the next cycle (1-cycle latency).
  - The pointer moves to winner+1 (mod NUM_M).
  - s_awid = {zero pad, winner index[clog2(NUM_M)-1:0], m_awid[MID_W-1:0]}.
  - The entry {winner, awlen} is pushed into the W-order FIFO in the same cycle as the grant.
  - s_aw* fields are held stable while s_awvalid=1 and s_awready=0.
  - No grant when the FIFO is full; a push and a pop in the same cycle are allowed even when the FIFO is full.
- W steering:
  - With the FIFO non-empty and head master h: s_wvalid=m_wvalid[h], s_wdata/wstrb/wlast from h, m_wready[h]=s_wready; all other m_wready=0. This path is combinational.
  - With the FIFO empty: s_wvalid=0 and all m_wready=0. W data that arrives before its AW is granted waits.
  - The beat counter increments on each s_w handshake.
  - On a handshake with s_wlast=1: pop the FIFO and clear the counter.
  - If the counter equals head awlen and s_wlast=0, or s_wlast=1 with counter != awlen: set wlast_err (sticky until reset). The pop still happens only on wlast.
- B routing:
  - idx = s_bid[MID_W+clog2(NUM_M)-1:MID_W].
  - If idx < NUM_M: m_bvalid[idx]=s_bvalid, m_bid[idx]=s_bid[MID_W-1:0], m_bresp[idx]=s_bresp, and s_bready=m_bready[idx]. Fully combinational; other m_bvalid stay 0.
  - If idx >= NUM_M: s_bready=1, the response is dropped, and bid_err pulses for one cycle per dropped handshake.

Test Plan:
- NUM_M=3; all three masters assert AW at once (awid=1,2,3), s_awready=1. Expect grants m0,m1,m2 on consecutive cycles, s_awid=0x01,0x12,0x23, and s_awvalid 1 cycle after each grant.
- Master 1 issues awlen=3 with 4 W beats; master 0 asserts W before its own AW. Expect no m_wready to master 0 until master 1 is granted and its 4 beats pass; FIFO pops on beat 4; wlast_err stays 0.
- WQ_DEPTH=4; issue 5 AWs with s_wready=0. Expect the 5th m_awready held 0. Complete one burst (wlast); expect the 5th AW granted in the same cycle as the pop.
- Slave returns s_bid=0x25 with bresp=2 and m_bready[2]=0 for 3 cycles. Expect m_bvalid[2]=1, m_bid[2]=5, m_bresp[2]=2, s_bready=0; handshake completes when m_bready[2]=1.
- awlen=1, then wlast on beat 1 → wlast_err=1. s_bid=0x35 → s_bready=1 and bid_err pulses for 1 cycle.
- Assert reset mid-burst with 2 FIFO entries pending. Expect all outputs at reset values immediately; after release, master 0 has first priority.
